// File: rtl/mdu_unit.sv
// mdu_unit: E-stage multiply/divide unit owning the architectural HI/LO pair.
// Results are computed at accept and held in pending registers. They are
// committed to HI/LO after a fixed busy latency, which models a multi-cycle
// datapath.
// Optional feature: define MDU_FLUSH_EN to add a Flush input that cancels an
// in-flight operation.
module mdu_unit #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [3:0]  MduOp,
   input  logic        En,
`ifdef MDU_FLUSH_EN
   input  logic        Flush,
`endif
   output logic        Start,
   output logic        Busy,
   output logic [31:0] Out,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   localparam int CMAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   logic [CW-1:0] cnt;
   logic [31:0]   pend_hi, pend_lo;
   logic          pend_wr;
   logic          flush;

   logic          is_mul, is_div, is_signed;
   logic [63:0]   prod;
   logic [31:0]   dvd, dvs, q_mag, r_mag;
   logic [31:0]   res_hi, res_lo;
   logic          res_wr;
   logic [CW-1:0] load_val;
   logic          commit;

`ifdef MDU_FLUSH_EN
   assign flush = Flush;
`else
   assign flush = 1'b0;
`endif

   assign Busy   = (cnt != '0);
   assign Start  = En && !Busy && (MduOp >= OP_MULT) && (MduOp <= OP_DIVU);
   assign commit = (cnt == CW'(1)) && pend_wr;

   // Operation decode and result datapath; division works on magnitudes so the
   // 0x80000000 / -1 case falls out naturally as 0x80000000 remainder 0.
   always_comb begin
      is_mul    = (MduOp == OP_MULT) || (MduOp == OP_MULTU);
      is_div    = (MduOp == OP_DIV)  || (MduOp == OP_DIVU);
      is_signed = (MduOp == OP_MULT) || (MduOp == OP_DIV);
      if (is_signed)
         prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
      else
         prod = {32'd0, A} * {32'd0, B};
      dvd    = (is_signed && A[31]) ? (~A + 32'd1) : A;
      dvs    = (B == 32'd0) ? 32'd1 : ((is_signed && B[31]) ? (~B + 32'd1) : B);
      q_mag  = dvd / dvs;
      r_mag  = dvd % dvs;
      res_hi = prod[63:32];
      res_lo = prod[31:0];
      res_wr = 1'b1;
      load_val = CW'(MUL_CYCLES);
      if (is_div) begin
         res_lo   = (is_signed && (A[31] ^ B[31])) ? (~q_mag + 32'd1) : q_mag;
         res_hi   = (is_signed && A[31]) ? (~r_mag + 32'd1) : r_mag;
         res_wr   = (B != 32'd0);
         load_val = CW'(DIV_CYCLES);
      end
      if (!is_mul && !is_div) res_wr = 1'b0;
   end

   // Busy counter and pending result registers; flush cancels everything.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_wr <= 1'b0;
      end else if (flush) begin
         cnt     <= '0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_wr <= 1'b0;
      end else if (Start) begin
         cnt     <= load_val;
         pend_hi <= res_hi;
         pend_lo <= res_lo;
         pend_wr <= res_wr;
      end else if (Busy) begin
         cnt <= cnt - CW'(1);
      end
   end

   // Architectural HI/LO: commit on the final countdown edge, else MTHI/MTLO.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         HI <= 32'd0;
         LO <= 32'd0;
      end else if (!flush) begin
         if (commit) begin
            HI <= pend_hi;
            LO <= pend_lo;
         end else if (En && !Busy) begin
            if (MduOp == OP_MTHI) HI <= A;
            if (MduOp == OP_MTLO) LO <= A;
         end
      end
   end

   // Move-from result path, muxed with the ALU result downstream.
   always_comb begin
      Out = 32'd0;
      if (MduOp == OP_MFHI) Out = HI;
      else if (MduOp == OP_MFLO) Out = LO;
   end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed vectors with hand-computed HI/LO, latency and
// hazard-visible outputs for mdu_unit. Covers the Flush path when
// MDU_FLUSH_EN is defined.
module tb_mdu_unit;

   localparam logic [3:0] NOP = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3,
                          DIVU = 4'd4, MFHI = 4'd5, MFLO = 4'd6, MTHI = 4'd7,
                          MTLO = 4'd8;

   logic        clk, reset_n;
   logic [31:0] a, b;
   logic [3:0]  mdu_op;
   logic        en;
   logic        start, busy;
   logic [31:0] out, hi, lo;
`ifdef MDU_FLUSH_EN
   logic        flush;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   mdu_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset_n(reset_n), .A(a), .B(b), .MduOp(mdu_op), .En(en),
`ifdef MDU_FLUSH_EN
      .Flush(flush),
`endif
      .Start(start), .Busy(busy), .Out(out), .HI(hi), .LO(lo)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mdu_op = NOP; en = 1'b0; a = 32'd0; b = 32'd0;
   endtask

   // Issue one mult/div op, then count the busy cycles that follow.
   task automatic run_op(input logic [3:0] op, input logic [31:0] oa, input logic [31:0] ob,
                         input int n_exp, input string tag);
      int cnt;
      mdu_op = op; a = oa; b = ob; en = 1'b1;
      #1;
      check({tag, " start"}, 32'(start), 32'd1);
      tick();
      idle_inputs();
      cnt = 0;
      while (busy && cnt < 100) begin
         cnt++;
         tick();
      end
      check({tag, " busy_cycles"}, 32'(cnt), 32'(n_exp));
   endtask

   initial begin
      int cnt;
      idle_inputs();
      reset_n = 1'b0;
`ifdef MDU_FLUSH_EN
      flush = 1'b0;
`endif
      #2;
      check("rst busy", 32'(busy), 32'd0);
      check("rst hi", hi, 32'd0);
      check("rst lo", lo, 32'd0);
      check("rst out", out, 32'd0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      run_op(MULT, 32'hFFFFFFFF, 32'h00000002, 5, "mult");
      check("mult hi", hi, 32'hFFFFFFFF);
      check("mult lo", lo, 32'hFFFFFFFE);

      run_op(MULTU, 32'hFFFFFFFF, 32'h00000002, 5, "multu");
      check("multu hi", hi, 32'h00000001);
      check("multu lo", lo, 32'hFFFFFFFE);

      run_op(DIV, 32'hFFFFFFF9, 32'h00000002, 10, "div");
      check("div lo", lo, 32'hFFFFFFFD);
      check("div hi", hi, 32'hFFFFFFFF);

      run_op(DIVU, 32'd7, 32'd2, 10, "divu");
      check("divu lo", lo, 32'd3);
      check("divu hi", hi, 32'd1);

      // MTHI is not a mult/div op and takes effect at the edge
      mdu_op = MTHI; a = 32'h12345678; en = 1'b1;
      #1;
      check("mthi start", 32'(start), 32'd0);
      tick();
      idle_inputs();
      check("mthi hi", hi, 32'h12345678);

      run_op(DIVU, 32'd5, 32'd0, 10, "divu0");
      check("divu0 hi", hi, 32'h12345678);
      check("divu0 lo", lo, 32'd3);

      run_op(DIV, 32'h80000000, 32'hFFFFFFFF, 10, "divovf");
      check("divovf lo", lo, 32'h80000000);
      check("divovf hi", hi, 32'h00000000);

      // ops presented while busy are ignored
      mdu_op = MULT; a = 32'd3; b = 32'd5; en = 1'b1;
      #1;
      check("mult35 start", 32'(start), 32'd1);
      tick();
      cnt = 0;
      for (int i = 0; i < 100 && busy; i++) begin
         cnt++;
         if (i == 0) begin mdu_op = MULT; a = 32'd7; b = 32'd7; en = 1'b1; end
         else if (i == 1) begin mdu_op = MTLO; a = 32'hDEADBEEF; en = 1'b1; end
         else idle_inputs();
         #1;
         if (i < 2) check("busy op start", 32'(start), 32'd0);
         if (i == 1) check("busy old lo", lo, 32'h80000000);
         tick();
      end
      idle_inputs();
      check("mult35 busy_cycles", 32'(cnt), 32'd5);
      check("mult35 lo", lo, 32'd15);
      check("mult35 hi", hi, 32'd0);
      mdu_op = MFLO; en = 1'b1;
      #1;
      check("mflo out", out, 32'd15);
      check("mflo start", 32'(start), 32'd0);
      idle_inputs();
      #1;
      check("nop out", out, 32'd0);

      // back-to-back: accepted in the first idle cycle
      tick();
      run_op(MULT, 32'h00012345, 32'h00010000, 5, "b2b");
      mdu_op = MFHI; en = 1'b1;
      #1;
      check("mfhi out", out, 32'h00000001);
      mdu_op = MFLO;
      #1;
      check("mflo2 out", out, 32'h23450000);
      idle_inputs();

      // asynchronous reset in the middle of an operation
      mdu_op = MULT; a = 32'd2; b = 32'd3; en = 1'b1;
      tick();
      idle_inputs();
      tick();
      reset_n = 1'b0;
      #1;
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst hi", hi, 32'd0);
      check("midrst lo", lo, 32'd0);
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      check("postrst lo", lo, 32'd0);
      check("postrst busy", 32'(busy), 32'd0);

`ifdef MDU_FLUSH_EN
      mdu_op = MTHI; a = 32'hAAAA0000; en = 1'b1;
      tick();
      mdu_op = MTLO; a = 32'h0000BBBB;
      tick();
      mdu_op = DIV; a = 32'd100; b = 32'd7; en = 1'b1;
      tick();
      idle_inputs();
      tick();
      tick();
      check("fl busy3", 32'(busy), 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl busy", 32'(busy), 32'd0);
      check("fl hi", hi, 32'hAAAA0000);
      check("fl lo", lo, 32'h0000BBBB);
      for (int i = 0; i < 12; i++) tick();
      check("fl hi late", hi, 32'hAAAA0000);
      check("fl lo late", lo, 32'h0000BBBB);
      mdu_op = MTHI; a = 32'h11111111; en = 1'b1; flush = 1'b1;
      tick();
      check("fl mthi hi", hi, 32'hAAAA0000);
      mdu_op = DIV; a = 32'd9; b = 32'd3;
      tick();
      check("fl start busy", 32'(busy), 32'd0);
      flush = 1'b0;
      idle_inputs();
      for (int i = 0; i < 12; i++) tick();
      check("fl start lo", lo, 32'h0000BBBB);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
